// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU with one combinational multiplier (latency 1).
module alu_muldiv_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3,
    parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     busy
);
    localparam int W  = DATA_WIDTH;
    localparam int AW = 2 * W + 1;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [W-1:0]             opnd_q, opnd_d;
    logic [AW-1:0]            acc_q, acc_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [W-1:0]             result_q, result_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;

    logic         in_is_div, in_a_signed, in_b_signed, in_neg_a, in_neg_b, in_overflow;
    logic [W-1:0] in_a_mag, in_b_mag;

    assign in_is_div   = Operation[2];
    assign in_a_signed = (Operation == OP_MULH) || (Operation == OP_MULHSU) ||
                         (Operation == OP_DIV)  || (Operation == OP_REM);
    assign in_b_signed = (Operation == OP_MULH) || (Operation == OP_DIV) || (Operation == OP_REM);
    assign in_neg_a    = in_a_signed && SrcA[W-1];
    assign in_neg_b    = in_b_signed && SrcB[W-1];
    assign in_a_mag    = in_neg_a ? -SrcA : SrcA;
    assign in_b_mag    = in_neg_b ? -SrcB : SrcB;
    assign in_overflow = in_is_div && !Operation[0] && (SrcA == MOST_NEG) && (SrcB == ALL_ONES);

`ifdef FAST_MUL_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{W{in_neg_a}}, SrcA};
    assign fast_b    = {{W{in_neg_b}}, SrcB};
    assign fast_prod = fast_a * fast_b;
`endif

    // Multiply step: add multiplicand on the low multiplier bit, then shift the whole accumulator right.
    logic [W:0]     mul_sum;
    logic [AW-1:0]  mul_next;
    // Divide step: shift remainder:quotient left, keep the trial subtraction when it does not go negative.
    logic [AW-1:0]  div_shift, div_next;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   quo_s, rem_s;

    assign mul_sum   = acc_q[AW-1:W] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[W-1:0]} >> 1;
    assign div_shift = {acc_q[AW-2:0], 1'b0};
    assign div_ge    = div_shift[AW-1:W] >= {1'b0, opnd_q};
    assign div_trial = div_shift[AW-1:W] - {1'b0, opnd_q};
    assign div_next  = div_ge ? {div_trial, div_shift[W-1:1], 1'b1} : div_shift;
    assign prod      = mul_next[2*W-1:0];
    assign prod_s    = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo_s     = (neg_a_q ^ neg_b_q) ? -div_next[W-1:0] : div_next[W-1:0];
    assign rem_s     = neg_a_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];

    function automatic logic [W-1:0] select_result(input logic [OPCODE_LENGTH-1:0] op,
                                                   input logic [2*W-1:0] p,
                                                   input logic [W-1:0] q,
                                                   input logic [W-1:0] r);
        if (!op[2]) return (op[1:0] == 2'b00) ? p[W-1:0] : p[2*W-1:W];
        return op[1] ? r : q;
    endfunction

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = Operation;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    opnd_d  = in_is_div ? in_b_mag : in_a_mag;
                    acc_d   = {{(W+1){1'b0}}, (in_is_div ? in_a_mag : in_b_mag)};
                    cnt_d   = CNT_WIDTH'(W);
                    state_d = CALC;
                    if (in_is_div && (SrcB == '0)) begin
                        result_d = Operation[1] ? SrcA : ALL_ONES;
                        state_d  = DONE;
                    end else if (in_overflow) begin
                        result_d = Operation[1] ? '0 : SrcA;
                        state_d  = DONE;
                    end
`ifdef FAST_MUL_EN
                    else if (!in_is_div) begin
                        result_d = select_result(Operation, fast_prod, '0, '0);
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    result_d = select_result(op_q, prod_s, quo_s, rem_s);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // out_valid trails entry into DONE by one edge and drops on the handshake edge.
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign busy      = busy_q;
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle, parametrised multiply/divide unit for the RV32M/RV64M extension; it is the sequential companion to the single-cycle integer ALU in the execute stage.
- Operands and an M-extension funct3 operation are accepted over a valid/ready handshake.
- The result is computed iteratively, one bit per cycle, and presented on a valid/ready output handshake.
- The pipeline stalls the execute stage while `busy` is high.

Parameters:
- DATA_WIDTH, 32: operand/result width; any even value >= 8.
- OPCODE_LENGTH, 3: Operation width (funct3 encoding).
- CNT_WIDTH, $clog2(DATA_WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands/Operation valid
- in_ready  output  1  unit can accept; high only in IDLE
- Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  DATA_WIDTH  rs1 operand
- SrcB  input  DATA_WIDTH  rs2 operand
- out_valid  output  1  Result valid
- out_ready  input  1  consumer takes Result
- Result  output  DATA_WIDTH  result of the operation
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset: rst_n low at a rising edge gives state=IDLE, in_ready=1, out_valid=0, busy=0, Result=0, counter=0, all internal registers 0. Reset applies mid-operation; any in-flight result is discarded with no output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch Operation, magnitudes of SrcA/SrcB, and sign flags per op:
    - signed for MULH, DIV, REM;
    - A signed, B unsigned for MULHSU;
    - unsigned otherwise.
  - Load counter=DATA_WIDTH, then go to CALC.
  - Special cases go directly to DONE:
    - Divide by zero (SrcB==0, ops 1xx): DIV/DIVU Result=all ones; REM/REMU Result=SrcA.
    - Signed overflow (DIV/REM, SrcA=most-negative, SrcB=all ones): DIV Result=SrcA; REM Result=0.
- CALC:
  - Multiply: shift-add over a 2*DATA_WIDTH accumulator, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle, unsigned magnitudes.
  - Counter decrements each cycle. When counter==1 at an edge, the final step completes and the state goes to DONE.
  - Sign correction is applied on that same edge:
    - product negated if signs differ;
    - quotient negated if signs differ;
    - remainder takes the dividend's sign.
  - Result selection: MUL = low half; MULH/MULHSU/MULHU = high half; DIV* = quotient; REM* = remainder.
- DONE:
  - out_valid=1; Result held stable.
  - On out_ready, return to IDLE and drop out_valid on the next edge.
  - The unit is not pipelined: in_ready=0 in DONE, so a new op accepted in the same cycle as the output handshake is not allowed. One idle cycle between ops is minimum.
- Latency, from the accepting edge to the edge that raises out_valid:
  - normal ops: DATA_WIDTH+1 cycles;
  - special cases: 1 cycle.
- Width rules: all arithmetic is modulo 2^DATA_WIDTH on output; internal accumulator is 2*DATA_WIDTH+1 bits; most-negative magnitude handled without overflow.
- out_ready may be high early; it has no effect before DONE.
- in_valid outside IDLE is ignored.

Optional Feature:
- FAST_MUL_EN defined:
  - Ops 0xx compute with a single combinational DATA_WIDTH x DATA_WIDTH multiply (sign-extended per op) in IDLE.
  - They skip CALC and reach DONE at the next edge; latency 1.
  - Divide ops are unchanged.
- FAST_MUL_EN undefined: all ops iterate as above.

Test Plan:
- Reset mid-CALC (MUL 7*6, rst_n low at cycle 10) -> next cycle: state IDLE, out_valid=0, in_ready=1, Result=0, busy=0.
- MUL 0xFFFFFFFF*0xFFFFFFFF; MULH same; MULHU same; MULHSU 0xFFFFFFFF*2 -> Result 0x00000001; 0x00000000; 0xFFFFFFFE; 0xFFFFFFFF. out_valid exactly 33 cycles after accept (1 with FAST_MUL_EN).
- DIV -7/2 = 0xFFFFFFFD; REM -7/2 = 0xFFFFFFFF; DIVU 100/7 = 14; REMU 100/7 = 2; each with 33-cycle latency.
- DIV/DIVU/REM/REMU 0x12345678/0 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x12345678, 0x12345678; latency 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency 1.
- Backpressure: out_ready low 5 cycles in DONE -> out_valid and Result held stable, in_ready=0; in_valid pulses ignored; after out_ready=1, IDLE next cycle and a new op is accepted.
